load_store_unit: RTL
====================

# load_store_unit

Sequential load/store sequencer between the execute result (address, store data, decoded opcode) and the doubleword-wide synchronous `data_memory`. It turns LEGv8 `LDUR*` and `STUR*` accesses of 1, 2, 4 or 8 bytes into aligned 64-bit memory transactions. Sub-word stores use read-modify-write so neighbouring bytes are preserved. Loads have their byte lane extracted and zero- or sign-extended. While an access is in flight, `stall` holds the PC.

## Interface
- `WORD`, default 64: datapath width; must be 64.
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: access request, sampled only in IDLE.
- `req_store`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
- `req_signed`  in  1: sign-extend load result (`LDURSW` and friends); ignored for stores.
- `address`  in  WORD: byte address.
- `write_data`  in  WORD: store data, low bytes significant.
- `mem_rdata`  in  WORD: memory read data, valid the cycle after `mem_read`.
- `mem_addr`  out  WORD: `{address[WORD-1:3], 3'b000}`, registered.
- `mem_read`  out  1: one-cycle read strobe.
- `mem_write`  out  1: one-cycle write strobe.
- `mem_wdata`  out  WORD: full doubleword to write.
- `stall`  out  1: high from accept until the cycle `done` is high (exclusive).
- `done`  out  1: one-cycle completion pulse.
- `read_data`  out  WORD: extended load result, held until next load completes.
- `misaligned`  out  1: qualifies `done`; access rejected.

## Operation
- States:
  - IDLE
  - RD: assert `mem_read`.
  - CAP: latch `mem_rdata`.
  - WR: assert `mem_write`.
  - FIN: assert `done`.
- Accept: in IDLE with `req_valid`, register address, data, size, signed and store flags. `stall` rises the same cycle, combinationally from `req_valid` in IDLE.
- Alignment: `address[2:0]` must be a multiple of 2^size. If not, go IDLE→FIN with `misaligned=1`; no memory strobe; `read_data` unchanged.
- Load: IDLE→RD→CAP→FIN.
  - In CAP, take lane `mem_rdata >> (8*address[2:0])`, truncate to the size.
  - Zero-extend, or sign-extend if `req_signed`; register into `read_data`.
- Store, size 3: IDLE→WR→FIN, with `mem_wdata = write_data`.
- Store, size 0–2: IDLE→RD→CAP→WR→FIN.
  - In CAP, merge: bytes `address[2:0]` to `address[2:0]+2^size-1` come from `write_data` low bytes; the rest come from `mem_rdata`.
- Lane mask: `(2^(8*2^size)-1) << (8*offset)`.
- FIN→IDLE unconditionally. A new request can be accepted in the cycle after FIN.
- Memory strobes are never asserted in IDLE or FIN.

## Timing
- Reset values:
  - state IDLE.
  - `stall`, `done`, `misaligned`, `mem_read`, `mem_write` are 0.
  - `mem_addr`, `mem_wdata`, `read_data` are 0.
- Latency from accept edge to `done`:
  - load: 3 cycles.
  - doubleword store: 2 cycles.
  - sub-word store: 4 cycles.
  - misaligned: 1 cycle.
- Reset wins over every state. Reset during RD/CAP/WR aborts with no further strobes. A partially merged store is dropped and memory is never written.
- `req_valid` outside IDLE is ignored. The requester holds inputs stable while `stall` is high; the unit relies only on its own registered copies.

## Structure
- Shared constants in `constants.vh`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`) and state encodings.
- The existing `STURB/STURH/STURW/LDUR*` opcode macros map to size and signed flags in the decoder, not here.
- One sub-module, `lane_merge`: purely combinational. It takes offset, size, old word and new data, and produces the merged store word and the extended load value. It is used in CAP.

## Test plan
- Load byte, signed: memory[0x10] = 0x0000_0000_0000_8000, address 0x11, size 0, signed → `done` 3 cycles after accept, `read_data` = 0xFFFF_FFFF_FFFF_FF80.
- Store word: memory[0x20] = 0x1111_2222_3333_4444, address 0x24, size 2, `write_data` = 0xAAAA_BBBB → RD, CAP and WR strobes in sequence, memory becomes 0xAAAA_BBBB_3333_4444, `done` at cycle 4.
- Store doubleword: address 0x08, data 0xDEAD_BEEF_CAFE_F00D → single `mem_write` on cycle 1, `done` at cycle 2, no `mem_read`.
- Misaligned half: address 0x03, size 1 → `done`=1 and `misaligned`=1 at cycle 1, zero strobes, `read_data` unchanged.
- Reset mid-store: assert `reset` in CAP of a byte store → no `mem_write`, outputs at reset values, memory unchanged.
- Back-to-back: an unsigned word load (memory word 0xFFFF_FFFF at offset 0) then a store issued the cycle after FIN → `read_data` = 0x0000_0000_FFFF_FFFF. `stall` is low for exactly the FIN→IDLE gap cycle. The second access completes correctly.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store sequencer: access sizes, FSM states,
// lane masks and alignment checks on a 64-bit doubleword.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SzB = 2'd0,
        SzH = 2'd1,
        SzW = 2'd2,
        SzD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StCap  = 3'd2,
        StWr   = 3'd3,
        StFin  = 3'd4
    } state_e;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        unique case (size_e'(size))
            SzB: size_mask = 64'h0000_0000_0000_00ff;
            SzH: size_mask = 64'h0000_0000_0000_ffff;
            SzW: size_mask = 64'h0000_0000_ffff_ffff;
            SzD: size_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    // Offset must be a multiple of the access size in bytes.
    function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
        unique case (size_e'(size))
            SzB: is_misaligned = 1'b0;
            SzH: is_misaligned = offset[0];
            SzW: is_misaligned = |offset[1:0];
            SzD: is_misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Byte-lane logic: merges store data into the old doubleword and extracts/extends
// the addressed lane for loads. Purely combinational.
module load_store_unit_lane_merge
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        is_signed_i,
    input  logic [63:0] old_word_i,
    input  logic [63:0] new_data_i,
    output logic [63:0] merged_o,
    output logic [63:0] load_value_o
);

    logic [5:0]  shamt;
    logic [63:0] mask;
    logic [63:0] lane;

    always_comb begin
        shamt        = {offset_i, 3'b000};
        mask         = size_mask(size_i);
        merged_o     = (old_word_i & ~(mask << shamt)) | ((new_data_i & mask) << shamt);
        lane         = (old_word_i >> shamt) & mask;
        load_value_o = lane;
        if (is_signed_i) begin
            unique case (size_e'(size_i))
                SzB: load_value_o = {{56{lane[7]}}, lane[7:0]};
                SzH: load_value_o = {{48{lane[15]}}, lane[15:0]};
                SzW: load_value_o = {{32{lane[31]}}, lane[31:0]};
                SzD: load_value_o = lane;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences LDUR*/STUR* accesses of 1..8 bytes into aligned doubleword memory
// transactions, using read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned WORD = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_store,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    input  logic [WORD-1:0] mem_rdata,
    output logic [WORD-1:0] mem_addr,
    output logic            mem_read,
    output logic            mem_write,
    output logic [WORD-1:0] mem_wdata,
    output logic            stall,
    output logic            done,
    output logic [WORD-1:0] read_data,
    output logic            misaligned
);

    state_e          state_q, state_d;
    logic [2:0]      offset_q, offset_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic            store_q, store_d;
    logic [WORD-1:0] mem_addr_q, mem_addr_d;
    logic [WORD-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD-1:0] read_data_q, read_data_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            done_q, done_d;
    logic            misaligned_q, misaligned_d;

    logic [WORD-1:0] merged;
    logic [WORD-1:0] load_value;

    load_store_unit_lane_merge u_lane_merge (
        .offset_i     (offset_q),
        .size_i       (size_q),
        .is_signed_i  (signed_q),
        .old_word_i   (mem_rdata),
        .new_data_i   (wdata_q),
        .merged_o     (merged),
        .load_value_o (load_value)
    );

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        store_d      = store_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        read_data_d  = read_data_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    offset_d   = address[2:0];
                    wdata_d    = write_data;
                    size_d     = req_size;
                    signed_d   = req_signed;
                    store_d    = req_store;
                    mem_addr_d = {address[WORD-1:3], 3'b000};
                    if (is_misaligned(address[2:0], req_size)) begin
                        state_d      = StFin;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else if (req_store && size_e'(req_size) == SzD) begin
                        state_d     = StWr;
                        mem_write_d = 1'b1;
                        mem_wdata_d = write_data;
                    end else begin
                        state_d    = StRd;
                        mem_read_d = 1'b1;
                    end
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                if (store_q) begin
                    state_d     = StWr;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = StFin;
                    done_d      = 1'b1;
                    read_data_d = load_value;
                end
            end
            StWr: begin
                state_d = StFin;
                done_d  = 1'b1;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            offset_q     <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            store_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            read_data_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            store_q      <= store_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            read_data_q  <= read_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Stall rises combinationally on the accepting cycle and drops in FIN.
    assign stall = !reset && ((state_q == StIdle && req_valid) ||
                              (state_q != StIdle && state_q != StFin));

    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign read_data  = read_data_q;
    assign misaligned = misaligned_q;

endmodule
